// File: rtl/led_pattern_pkg.sv
// Shared types and constants for the LED pattern sequencer: the display mode
// enum, the number of modes and the PWM counter width.
package led_pattern_pkg;

    typedef enum logic [1:0] {
        BLINK  = 2'd0,
        CHASE  = 2'd1,
        BOUNCE = 2'd2,
        COUNT  = 2'd3
    } mode_t;

    localparam int MODE_COUNT = 4;
    localparam int PWM_W      = 4;

    // One button press moves to the following mode; the last mode wraps to the first.
    function automatic mode_t next_mode(input mode_t m);
        if (m == mode_t'(2'(MODE_COUNT - 1)))
            return BLINK;
        return mode_t'(m + 2'd1);
    endfunction

endpackage

// File: rtl/led_btn_debounce.sv
// Button conditioning: 2-FF synchroniser, level debouncer and press-edge detector.
// The debounced level (1 = released) doubles as the observable debouncer state.
module led_btn_debounce #(
    parameter int DEB_CYC = 100_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYC - 1);

    if (DEB_CYC < 1) begin : g_chk_deb_cyc
        $error("led_btn_debounce: DEB_CYC must be at least 1");
    end

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // cnt counts consecutive samples that disagree with the accepted level;
    // the level flips on the DEB_CYC-th such sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            cnt   <= '0;
            level <= 1'b1;
            press <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                cnt   <= '0;
                level <= sync2;
                press <= level & ~sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: a debounced button cycles BLINK/CHASE/BOUNCE/COUNT,
// each pattern stepping once per prescaler tick. Active-low registered LED drive.
// Optional brightness PWM is compiled in with LED_PATTERN_SEQ_PWM_EN.
module led_pattern_seq
    import led_pattern_pkg::*;
#(
    parameter int LED_W    = 8,
    parameter int TICK_DIV = 2_500_000,
    parameter int DEB_CYC  = 100_000,
    parameter int PWM_DUTY = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_button,
    output logic [LED_W-1:0] led
);

    localparam int IDX_W = (LED_W > 1) ? $clog2(LED_W) : 1;
    localparam int PRE_W = $clog2(TICK_DIV);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(LED_W - 1);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    if (LED_W < 1 || LED_W > 32) begin : g_chk_led_w
        $error("led_pattern_seq: LED_W must be in 1..32");
    end
    if (TICK_DIV < 2) begin : g_chk_tick_div
        $error("led_pattern_seq: TICK_DIV must be at least 2");
    end
    if (DEB_CYC < 1) begin : g_chk_deb_cyc
        $error("led_pattern_seq: DEB_CYC must be at least 1");
    end
    if (PWM_DUTY < 0 || PWM_DUTY > 16) begin : g_chk_pwm_duty
        $error("led_pattern_seq: PWM_DUTY must be in 0..16");
    end

    logic             press;
    logic             deb_level_unused;
    mode_t            mode;
    logic [PRE_W-1:0] presc;
    logic [IDX_W-1:0] idx;
    logic             dir_down;
    logic [LED_W-1:0] cnt;
    logic             phase;
    logic             tick;
    logic [LED_W-1:0] lit;
    logic [LED_W-1:0] lit_gated;

    led_btn_debounce #(
        .DEB_CYC (DEB_CYC)
    ) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .btn   (push_button),
        .level (deb_level_unused),
        .press (press)
    );

    assign tick = (presc == PRE_MAX);

    always_comb begin
        lit = '0;
        case (mode)
            BLINK:         lit = phase ? '1 : LED_W'(1);
            CHASE, BOUNCE: lit = LED_W'(1) << idx;
            COUNT:         lit = cnt;
            default:       lit = '0;
        endcase
    end

`ifdef LED_PATTERN_SEQ_PWM_EN
    localparam int PWM_CMP_W = PWM_W + 1;
    localparam logic [PWM_W:0] PWM_LIMIT = PWM_CMP_W'(PWM_DUTY);

    logic [PWM_W-1:0] pwm_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pwm_cnt <= '0;
        else
            pwm_cnt <= pwm_cnt + 1'b1;
    end

    assign lit_gated = ({1'b0, pwm_cnt} < PWM_LIMIT) ? lit : '0;
`else
    assign lit_gated = lit;
`endif

    // A press restarts the new mode from its initial state and swallows any
    // tick that lands on the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode     <= BLINK;
            presc    <= '0;
            idx      <= '0;
            dir_down <= 1'b0;
            cnt      <= '0;
            phase    <= 1'b0;
            led      <= '1;
        end else begin
            led <= ~lit_gated;
            if (press) begin
                mode     <= next_mode(mode);
                presc    <= '0;
                idx      <= '0;
                dir_down <= 1'b0;
                cnt      <= '0;
                phase    <= 1'b0;
            end else begin
                presc <= tick ? '0 : presc + 1'b1;
                if (tick) begin
                    case (mode)
                        BLINK: phase <= ~phase;
                        CHASE: idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
                        BOUNCE: begin
                            // Reverse on reaching an end so each endpoint shows for one tick.
                            if (LED_W > 1) begin
                                if (!dir_down) begin
                                    if (idx == IDX_MAX) begin
                                        dir_down <= 1'b1;
                                        idx      <= idx - 1'b1;
                                    end else begin
                                        idx <= idx + 1'b1;
                                    end
                                end else begin
                                    if (idx == '0) begin
                                        dir_down <= 1'b0;
                                        idx      <= idx + 1'b1;
                                    end else begin
                                        idx <= idx - 1'b1;
                                    end
                                end
                            end
                        end
                        COUNT:   cnt <= cnt + 1'b1;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_seq.sv
// Self-checking bench for led_pattern_seq (LED_W=8, TICK_DIV=4, DEB_CYC=3) with a
// second LED_W=1 instance sharing clock, reset and button.
module tb_led_pattern_seq;

    localparam int LED_W    = 8;
    localparam int TICK_DIV = 4;
    localparam int DEB_CYC  = 3;
    localparam int PWM_DUTY = 4;

    logic       clk;
    logic       rst;
    logic       push_button;
    logic [7:0] led;
    logic [0:0] led1;

    led_pattern_seq #(
        .LED_W    (LED_W),
        .TICK_DIV (TICK_DIV),
        .DEB_CYC  (DEB_CYC),
        .PWM_DUTY (PWM_DUTY)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .push_button (push_button),
        .led         (led)
    );

    led_pattern_seq #(
        .LED_W    (1),
        .TICK_DIV (TICK_DIV),
        .DEB_CYC  (DEB_CYC),
        .PWM_DUTY (PWM_DUTY)
    ) u_dut1 (
        .clk         (clk),
        .rst         (rst),
        .push_button (push_button),
        .led         (led1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard and reference model state
    logic [7:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         m_mode = 0;
    int         m_k = 0;
    int         m_presc = 0;
    int         m_pwm = 0;
    int         m_press_cyc = -1;
    string      cur_test = "none";

    // Pattern k ticks after entering a mode, straight from the pattern definitions.
    function automatic logic [7:0] model_lit(input int mode, input int k);
        logic [7:0] one;
        int         p;
        one = 8'h01;
        case (mode)
            0:       return (k % 2 == 0) ? 8'h01 : 8'hFF;
            1:       return one << (k % 8);
            2: begin
                p = k % 14;
                return one << ((p < 8) ? p : 14 - p);
            end
            default: return 8'(k % 256);
        endcase
    endfunction

    // One clock: advance the model at the posedge, push its prediction, then pop
    // and compare against the DUT at the following negedge.
    task automatic step();
        logic [7:0] lit_v;
        logic [7:0] exp_v;
        logic [7:0] got_exp;
        @(posedge clk);
        cyc++;
        if (!rst) begin
            m_mode      = 0;
            m_k         = 0;
            m_presc     = 0;
            m_pwm       = 0;
            m_press_cyc = -1;
            exp_v       = 8'hFF;
        end else begin
            lit_v = model_lit(m_mode, m_k);
`ifdef LED_PATTERN_SEQ_PWM_EN
            if (m_pwm >= PWM_DUTY)
                lit_v = 8'h00;
            m_pwm = (m_pwm + 1) % 16;
`endif
            exp_v = ~lit_v;
            if (cyc == m_press_cyc) begin
                m_mode  = (m_mode + 1) % 4;
                m_k     = 0;
                m_presc = 0;
            end else if (m_presc == TICK_DIV - 1) begin
                m_presc = 0;
                m_k++;
            end else begin
                m_presc++;
            end
        end
        exp_q.push_back(exp_v);
        @(negedge clk);
        got_exp = exp_q.pop_front();
        checks++;
        if (led !== got_exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: led=%h expected %h", cur_test, cyc, led, got_exp);
        end
    endtask

    // driver: hold the button low for 'hold' cycles, then let it settle released
    task automatic press_button(input int hold);
        push_button = 1'b0;
        if (hold >= DEB_CYC)
            m_press_cyc = cyc + 2 + DEB_CYC + 1;
        repeat (hold) step();
        push_button = 1'b1;
        repeat (8) step();
    endtask

    task automatic test_reset();
        cur_test = "reset";
        #2 rst = 1'b0;
        #1;
        checks++;
        if (led !== 8'hFF) begin
            errors++;
            $display("FAIL reset_async: led=%h expected ff", led);
        end
        repeat (3) step();
        rst = 1'b1;
    endtask

    task automatic test_blink();
        cur_test = "blink";
        repeat (20) step();
    endtask

    task automatic test_short_press();
        cur_test = "short_press";
        press_button(2);
        repeat (12) step();
    endtask

    task automatic test_chase();
        cur_test = "chase";
        press_button(6);
        repeat (40) step();
    endtask

    task automatic test_bounce();
        cur_test = "bounce";
        press_button(6);
        repeat (64) begin
            step();
            checks++;
            if (led1 !== 1'b0) begin
                errors++;
                $display("FAIL bounce_w1 cyc=%0d: led1=%b expected 0", cyc, led1);
            end
        end
    endtask

    task automatic test_count();
        cur_test = "count";
        press_button(6);
        repeat (256 * TICK_DIV + 8) step();
    endtask

    // Reset while counting with a press half-debounced; nothing may survive it.
    task automatic test_reset_mid();
        cur_test = "reset_mid";
        push_button = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        #1;
        checks++;
        if (led !== 8'hFF) begin
            errors++;
            $display("FAIL reset_mid_async: led=%h expected ff", led);
        end
        repeat (3) step();
        rst = 1'b1;
        push_button = 1'b1;
        repeat (20) step();
    endtask

    task automatic test_wrap();
        cur_test = "wrap";
        repeat (4) press_button(6);
        repeat (12) step();
    endtask

    task automatic test_press_tick();
        int guard;
        cur_test = "press_tick";
        guard = 0;
        while (m_presc != 2 && guard < 8) begin
            step();
            guard++;
        end
        checks++;
        if (m_presc != 2) begin
            errors++;
            $display("FAIL press_tick_align: presc=%0d expected 2", m_presc);
        end
        press_button(6);
        repeat (20) step();
    endtask

    initial begin
        rst = 1'b1;
        push_button = 1'b1;
        test_reset();
        test_blink();
        test_short_press();
        test_chase();
        test_bounce();
        test_count();
        test_reset_mid();
        test_wrap();
        test_press_tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
